// File: rtl/hazard_stall_controller.sv
// Pipeline interlock for the 5-stage core: load-use bubbles (LOAD_LAT per hazard),
// multi-cycle EX hold (MC_LAT cycles total), ID-stage branch flush and a
// saturating stall-cycle counter. All control outputs are combinational from
// the current state and inputs.
module hazard_stall_controller #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MC_LAT   = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              EX_MemRead_i,
    input  logic [REG_AW-1:0] EX_RegDest_i,
    input  logic              EX_MultiCycle_i,
    input  logic [REG_AW-1:0] ID_Rs1_i,
    input  logic [REG_AW-1:0] ID_Rs2_i,
    input  logic              ID_UseRs1_i,
    input  logic              ID_UseRs2_i,
    input  logic              ID_FlushReq_i,
    output logic              NoOp_o,
    output logic              Stall_o,
    output logic              PCWrite_o,
    output logic              EXHold_o,
    output logic              Flush_o,
    output logic [CNT_W-1:0]  StallCnt_o
);

    localparam int MAX_LAT = (LOAD_LAT > MC_LAT) ? LOAD_LAT : MC_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    // Remaining cycles after the entry cycle, counted down to zero.
    localparam logic [CW-1:0] LD_INIT = (LOAD_LAT > 1) ? CW'(LOAD_LAT - 2) : '0;
    localparam logic [CW-1:0] MC_INIT = CW'(MC_LAT - 2);

    typedef enum logic [1:0] {
        IDLE,
        LD_STALL,
        MC_BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic               hz;
    logic               noop_d, stall_d, pcwrite_d, exhold_d;

    // Load-use hazard; a load to x0 never creates a dependency.
    assign hz = EX_MemRead_i && (EX_RegDest_i != '0) &&
                ((ID_UseRs1_i && (ID_Rs1_i == EX_RegDest_i)) ||
                 (ID_UseRs2_i && (ID_Rs2_i == EX_RegDest_i)));

    // Next-state and control outputs; everything held at idle values while reset is asserted.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        noop_d    = 1'b0;
        stall_d   = 1'b0;
        pcwrite_d = 1'b1;
        exhold_d  = 1'b0;
        if (rst_i) begin
            case (state_q)
                IDLE: begin
                    if (EX_MultiCycle_i) begin
                        // Multi-cycle op wins over a simultaneous load-use hazard.
                        exhold_d  = 1'b1;
                        stall_d   = 1'b1;
                        pcwrite_d = 1'b0;
                        cnt_d     = MC_INIT;
                        state_d   = MC_BUSY;
                    end else if (hz) begin
                        noop_d    = 1'b1;
                        stall_d   = 1'b1;
                        pcwrite_d = 1'b0;
                        if (LOAD_LAT > 1) begin
                            cnt_d   = LD_INIT;
                            state_d = LD_STALL;
                        end
                    end
                end
                LD_STALL: begin
                    // Load has left EX, so hz is not re-evaluated here.
                    noop_d    = 1'b1;
                    stall_d   = 1'b1;
                    pcwrite_d = 1'b0;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                MC_BUSY: begin
                    exhold_d  = 1'b1;
                    stall_d   = 1'b1;
                    pcwrite_d = 1'b0;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and bubble counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_d && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign NoOp_o     = noop_d;
    assign Stall_o    = stall_d;
    assign PCWrite_o  = pcwrite_d;
    assign EXHold_o   = exhold_d;
    // A stalled ID instruction is not final; the branch re-presents after release.
    assign Flush_o    = rst_i && ID_FlushReq_i && !stall_d;
    assign StallCnt_o = stall_cnt_q;

endmodule
